// File: rtl/cpu_pkg.sv
// Shared CPU definitions: trap opcodes, preemption FSM states and the OS entry
// vectors that the PC-select logic and this controller must agree on.
package cpu_pkg;
  localparam logic [5:0] OP_IN  = 6'b011101;
  localparam logic [5:0] OP_OUT = 6'b011110;
  localparam logic [5:0] OP_FIM = 6'b011111;

  typedef enum logic [1:0] {KERNEL, RUN, WAIT} state_t;

  // OS routine entry addresses, shared with the CPU's PC mux
  localparam int NUM_OS_VEC = 5;
  localparam logic [NUM_OS_VEC-1:0][31:0] OS_VEC = {32'd236, 32'd180, 32'd160, 32'd92, 32'd73};
endpackage

// File: rtl/quantum_counter.sv
// Loadable up-counter with clear/enable and a terminal-count compare against TC.
module quantum_counter #(
  parameter int CNT_W = 8,
  parameter logic [CNT_W-1:0] TC = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);
  always_ff @(posedge clock) begin
    if (!reset)    count <= '0;
    else if (clr)  count <= '0;
    else if (load) count <= loadVal;
    else if (en)   count <= count + 1'b1;
  end

  assign tc = (count == TC);
endmodule

// File: rtl/quantum_preempt_ctrl.sv
// Preemption/trap controller ahead of PC select: quantum expiry, user I/O and
// end-of-process traps, plus the PC the OS save routine must store.
module quantum_preempt_ctrl import cpu_pkg::*; #(
  parameter int         QUANTUM = 8,
  parameter logic [5:0] OP_IN   = cpu_pkg::OP_IN,
  parameter logic [5:0] OP_OUT  = cpu_pkg::OP_OUT,
  parameter logic [5:0] OP_FIM  = cpu_pkg::OP_FIM,
  parameter int         CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      pc,
  input  logic [5:0]       opcode,
  input  logic [31:0]      processo_atual,
  input  logic             halt,
  input  logic             ctx_resume,
  output logic             troca_contexto,
  output logic             io_trap,
  output logic             fim_processo,
  output logic [31:0]      pc_salvo,
  output logic [CNT_W-1:0] quantum_restante
);
  localparam logic [CNT_W-1:0] QMAX = CNT_W'(QUANTUM);

  state_t           state, nextState;
  logic [CNT_W-1:0] count;
  logic             tc, kernelPid, evOk, isFim, isIo, anyEv;

  assign kernelPid = (processo_atual == 32'd0);
  assign isFim     = (opcode == OP_FIM);
  assign isIo      = (opcode == OP_IN) || (opcode == OP_OUT);
  // An instruction retires in RUN only when nothing else owns the cycle;
  // reset also masks pulses so a request coinciding with reset is dropped.
  assign evOk      = reset && (state == RUN) && !kernelPid && !ctx_resume && !halt;
  assign anyEv     = troca_contexto || io_trap || fim_processo;

  quantum_counter #(.CNT_W(CNT_W), .TC(QMAX)) uCnt (
    .clock  (clock),
    .reset  (reset),
    .clr    ((state != RUN) || kernelPid || ctx_resume || anyEv),
    .load   (1'b0),
    .loadVal('0),
    .en     (evOk),
    .count  (count),
    .tc     (tc)
  );

  always_ff @(posedge clock) begin
    if (!reset) state <= KERNEL;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      KERNEL: if (ctx_resume && !kernelPid) nextState = RUN;
      RUN: begin
        if (kernelPid)  nextState = KERNEL;
        else if (anyEv) nextState = WAIT;
      end
      WAIT: begin
        if (ctx_resume)     nextState = RUN;
        else if (kernelPid) nextState = KERNEL;
      end
      default: nextState = KERNEL;
    endcase
  end

  always_comb begin
    fim_processo   = evOk && isFim;
    io_trap        = evOk && !isFim && isIo;
    troca_contexto = evOk && !isFim && !isIo && tc;
  end

  always_ff @(posedge clock) begin
    if (!reset)                               pc_salvo <= '0;
    else if (fim_processo || troca_contexto)  pc_salvo <= pc;
    else if (io_trap)                         pc_salvo <= pc + 32'd1;
  end

  assign quantum_restante = (count >= QMAX) ? '0 : QMAX - count;
endmodule

// File: tb/tb_quantum_preempt_ctrl.sv
// Directed bench for quantum_preempt_ctrl with a behavioural reference model
// feeding a per-cycle expectation queue.
module tb_quantum_preempt_ctrl;
  localparam int Q = 8;
  localparam logic [5:0] OPI = 6'b011101, OPO = 6'b011110, OPF = 6'b011111, NOP = 6'b000001;

  logic        clock = 1'b0, reset, halt, ctx_resume;
  logic [31:0] pc, processo_atual;
  logic [5:0]  opcode;
  logic        troca_contexto, io_trap, fim_processo;
  logic [31:0] pc_salvo;
  logic [7:0]  quantum_restante;

  quantum_preempt_ctrl #(.QUANTUM(Q)) dut (
    .clock(clock), .reset(reset), .pc(pc), .opcode(opcode),
    .processo_atual(processo_atual), .halt(halt), .ctx_resume(ctx_resume),
    .troca_contexto(troca_contexto), .io_trap(io_trap), .fim_processo(fim_processo),
    .pc_salvo(pc_salvo), .quantum_restante(quantum_restante)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       troca, io, fim;
    logic [7:0] qr;
    logic [31:0] pcs;
  } exp_t;

  exp_t q[$];
  int   tests = 0, fails = 0;
  int   mSt = 0, mCnt = 0;   // 0 kernel, 1 run, 2 wait
  logic [31:0] mPcs = 0;
  int   trocaCycles = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input bit r, input logic [31:0] p, input logic [5:0] o,
                      input logic [31:0] pr, input bit h, input bit res);
    exp_t e;
    bit ok;
    @(negedge clock);
    reset = r; pc = p; opcode = o; processo_atual = pr; halt = h; ctx_resume = res;
    ok = r && mSt == 1 && pr != 0 && !res && !h;
    e.fim   = ok && o == OPF;
    e.io    = ok && o != OPF && (o == OPI || o == OPO);
    e.troca = ok && o != OPF && o != OPI && o != OPO && mCnt == Q;
    e.qr    = (mCnt >= Q) ? 8'd0 : 8'(Q - mCnt);
    if (!r) begin
      mSt = 0; mCnt = 0; mPcs = 0;
    end else begin
      case (mSt)
        0: begin mCnt = 0; if (res && pr != 0) mSt = 1; end
        1: begin
          if (pr == 0)       begin mSt = 0; mCnt = 0; end
          else if (res)      mCnt = 0;
          else if (h)        ;
          else if (e.fim || e.troca) begin mPcs = p; mSt = 2; mCnt = 0; end
          else if (e.io)     begin mPcs = p + 32'd1; mSt = 2; mCnt = 0; end
          else               mCnt++;
        end
        default: begin mCnt = 0; if (res) mSt = 1; else if (pr == 0) mSt = 0; end
      endcase
    end
    e.pcs = mPcs;
    q.push_back(e);
    #3;
    e = q.pop_front();
    check("troca_contexto", 32'(troca_contexto), 32'(e.troca));
    check("io_trap", 32'(io_trap), 32'(e.io));
    check("fim_processo", 32'(fim_processo), 32'(e.fim));
    check("quantum_restante", 32'(quantum_restante), 32'(e.qr));
    if (troca_contexto === 1'b1) trocaCycles++;
    @(posedge clock); #1;
    check("pc_salvo", pc_salvo, e.pcs);
  endtask

  initial begin
    reset = 0; pc = 0; opcode = NOP; processo_atual = 0; halt = 0; ctx_resume = 0;
    // reset
    step(0, 0, NOP, 0, 0, 0);
    step(0, 0, NOP, 0, 0, 0);
    // full quantum expiry at pc 308
    step(1, 299, NOP, 1, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 300 + i, NOP, 1, 0, 0);
    check("qr_at_expiry", 32'(quantum_restante), 0);
    step(1, 308, NOP, 1, 0, 0);
    check("pcs308", pc_salvo, 308);
    check("troca_once", trocaCycles, 1);
    for (int i = 0; i < 3; i++) step(1, 308, NOP, 1, 0, 0);
    // I/O trap wins over expiry
    step(1, 296, NOP, 1, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 297 + i, NOP, 1, 0, 0);
    step(1, 305, OPI, 1, 0, 0);
    check("pcs306", pc_salvo, 306);
    // end of process, then quiet WAIT
    step(1, 609, NOP, 2, 0, 1);
    step(1, 610, NOP, 2, 0, 0);
    step(1, 611, NOP, 2, 0, 0);
    step(1, 612, OPF, 2, 0, 0);
    check("pcs612", pc_salvo, 612);
    for (int i = 0; i < 3; i++) step(1, 613, OPF, 2, 0, 0);
    // halt freezes the quantum for 5 cycles
    trocaCycles = 0;
    step(1, 700, NOP, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 700 + i, NOP, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 703, OPI, 1, 1, 0);
    check("qr_halted", 32'(quantum_restante), 5);
    for (int i = 0; i < 5; i++) step(1, 703 + i, NOP, 1, 0, 0);
    check("troca_not_early", trocaCycles, 0);
    step(1, 708, NOP, 1, 0, 0);
    check("troca_delayed", trocaCycles, 1);
    // kernel never preempted
    for (int i = 0; i < 20; i++) step(1, 41, NOP, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 42 + i, NOP, 1, 0, 0);
    // resume mid-quantum restarts, OP_OUT at top of memory wraps pc+1
    step(1, 10, NOP, 3, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 11 + i, NOP, 3, 0, 0);
    step(1, 17, NOP, 3, 0, 1);
    check("qr_restart", 32'(quantum_restante), Q);
    for (int i = 0; i < 8; i++) step(1, 18 + i, NOP, 3, 0, 0);
    step(1, 32'hFFFF_FFFF, OPO, 3, 0, 0);
    check("pcs_wrap", pc_salvo, 0);
    // reset coincides with expiry
    step(1, 500, NOP, 4, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 500 + i, NOP, 4, 0, 0);
    step(0, 508, NOP, 4, 0, 0);
    check("pcs_reset", pc_salvo, 0);
    for (int i = 0; i < 10; i++) step(1, 509 + i, NOP, 4, 0, 0);
    check("qr_kernel", 32'(quantum_restante), Q);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
